// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-side sram-like bus between the fetch controller (master) and
// the instruction memory (slave): request/addr_ok then in-order data_ok/rdata.
interface fetch_redirect_ctrl_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Front-end fetch controller: owns the PC, issues fetches on the sram-like
// instruction bus, applies WB/ID redirects, cancels stale in-flight responses
// and hands {pc, inst, adef} to ID over a valid/allowin handshake.
// Optional build macro FETCH_PERF_CNT_EN adds redirect/cancel event counters.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wb_ex,
    input  logic [31:0]                  eentry,
    input  logic                         wb_ertn,
    input  logic [31:0]                  csr_era,
    input  logic                         wb_refetch,
    input  logic [31:0]                  refetch_pc,
    input  logic                         br_taken,
    input  logic [31:0]                  br_target,
    fetch_redirect_ctrl_if.master        inst_sram,
    input  logic                         ds_allowin,
    output logic                         fs_to_ds_valid,
    output logic [31:0]                  fs_pc,
    output logic [31:0]                  fs_inst,
    output logic                         fs_adef
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_redir_cnt,
    output logic [31:0]                  perf_cancel_cnt
`endif
);

    typedef enum logic [1:0] {StReq, StWait, StFull} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        inst_q, inst_d;
    logic               adef_q, adef_d;

    logic               redir;
    logic [31:0]        tgt;
    logic               misaligned;
    logic               req_now;
    logic               live_ok;
    logic               cnt_inc;
    logic               cnt_dec;
    logic               valid_now;

    assign redir      = wb_ex | wb_ertn | wb_refetch | br_taken;
    assign misaligned = |pc_q[1:0];
    assign req_now    = (state_q == StReq) && !misaligned;
    // With no stale responses pending, a data_ok belongs to the live fetch.
    assign live_ok    = inst_sram.inst_sram_data_ok && (cnt_q == '0) && (state_q == StWait);
    assign cnt_dec    = inst_sram.inst_sram_data_ok && (cnt_q != '0);

    // Redirect target selection: WB sources beat the ID branch.
    always_comb begin
        tgt = br_target;
        if (wb_ex) begin
            tgt = eentry;
        end else if (wb_ertn) begin
            tgt = csr_era;
        end else if (wb_refetch) begin
            tgt = refetch_pc;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            inst_q       <= '0;
            adef_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            adef_q       <= adef_d;
        end
    end

    // Next-state: fetch sequencing and redirect handling.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        inst_d       = inst_q;
        adef_d       = adef_q;
        cnt_inc      = 1'b0;
        case (state_q)
            StReq: begin
                if (misaligned) begin
                    // No bus traffic for a bad address; a redirect just retargets.
                    if (redir) begin
                        pc_d = tgt;
                    end else begin
                        state_d = StFull;
                        inst_d  = '0;
                        adef_d  = 1'b1;
                    end
                end else if (inst_sram.inst_sram_addr_ok) begin
                    if (redir || pend_valid_q) begin
                        // The request just accepted is stale; refetch from the new target.
                        cnt_inc      = 1'b1;
                        pc_d         = redir ? tgt : pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end else if (redir) begin
                    // Address must stay stable until accepted, so park the target.
                    pend_pc_d    = tgt;
                    pend_valid_d = 1'b1;
                end
            end
            StWait: begin
                if (redir) begin
                    // A live response arriving now is simply dropped; otherwise cancel it later.
                    cnt_inc = !live_ok;
                    pc_d    = tgt;
                    state_d = StReq;
                end else if (live_ok) begin
                    inst_d  = inst_sram.inst_sram_rdata;
                    adef_d  = 1'b0;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = StReq;
                end else if (ds_allowin) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Cancel counter: increments and decrements in one cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(cnt_inc && !cnt_dec && (cnt_q == CntMax)));

    // Outputs: bus request and ID-facing payload, all forced quiet during reset.
    always_comb begin
        valid_now                = resetn && (state_q == StFull);
        inst_sram.inst_sram_req  = resetn && req_now;
        inst_sram.inst_sram_addr = pc_q;
        fs_to_ds_valid           = valid_now;
        fs_pc                    = valid_now ? pc_q : 32'd0;
        fs_inst                  = valid_now ? inst_q : 32'd0;
        fs_adef                  = valid_now && adef_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redir_q;
    logic [31:0] perf_cancel_q;

    // Event counters; they wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_redir_q  <= '0;
            perf_cancel_q <= '0;
        end else begin
            perf_redir_q  <= perf_redir_q + {31'd0, redir};
            perf_cancel_q <= perf_cancel_q + {31'd0, cnt_dec};
        end
    end

    assign perf_redir_cnt  = perf_redir_q;
    assign perf_cancel_cnt = perf_cancel_q;
`endif

endmodule
